// File: rtl/move_commit.sv
// move_commit: applies a chess move to an externally owned board.
// A request is checked against the board and the side to move.
// A legal move is written as two strobed board writes: the destination first, then the cleared source.
// An illegal move produces a single error pulse instead.
// Optional feature: define MOVE_COMMIT_PROMOTION_EN to turn a pawn that reaches the last row into a queen.
module move_commit (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [255:0] board_input,
    input  logic         move_valid,
    input  logic [5:0]   move_src,
    input  logic [5:0]   move_dst,
    output logic         move_ready,
    output logic [5:0]   board_out_addr,
    output logic [3:0]   board_out_piece,
    output logic         board_change_enable,
    output logic         move_done,
    output logic         move_error,
    output logic [3:0]   captured_piece,
    output logic         side_to_move,
    output logic [7:0]   move_count
);

    typedef enum logic [2:0] {IDLE, WR_DST, WR_SRC, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [5:0]  src_q, src_d;
    logic [3:0]  dst_piece_q, dst_piece_d;
    logic        ready_q, ready_d;
    logic [5:0]  addr_q, addr_d;
    logic [3:0]  piece_q, piece_d;
    logic        en_q, en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [3:0]  cap_q, cap_d;
    logic        side_q, side_d;
    logic [7:0]  count_q, count_d;

    logic [3:0]  src_piece_w, dst_piece_w, moved_w;
    logic        reject_w;

    // Look up both squares of the request and decide whether it is legal.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
        src_piece_w = board_input[{move_src, 2'b00} +: 4];
        dst_piece_w = board_input[{move_dst, 2'b00} +: 4];
        moved_w     = src_piece_w;
`ifdef MOVE_COMMIT_PROMOTION_EN
        if (src_piece_w[2:0] == 3'b001 &&
            ((!src_piece_w[3] && move_dst[5:3] == 3'd0) ||
             ( src_piece_w[3] && move_dst[5:3] == 3'd7)))
            moved_w = {src_piece_w[3], 3'b101};
`endif
        reject_w = (src_piece_w[2:0] == 3'b000) ||
                   (src_piece_w[3] != side_q) ||
                   (move_src == move_dst) ||
                   ((dst_piece_w[2:0] != 3'b000) && (dst_piece_w[3] == src_piece_w[3]));
    end

    // Compute the next state and the values every output takes in that state.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_piece_d = dst_piece_q;
        ready_d     = 1'b0;
        addr_d      = '0;
        piece_d     = '0;
        en_d        = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cap_d       = cap_q;
        side_d      = side_q;
        count_d     = count_q;
        unique case (state_q)
            IDLE: begin
                if (move_valid) begin
                    src_d       = move_src;
                    dst_piece_d = dst_piece_w;
                    if (reject_w) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WR_DST;
                        en_d    = 1'b1;
                        addr_d  = move_dst;
                        piece_d = moved_w;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            WR_DST: begin
                state_d = WR_SRC;
                en_d    = 1'b1;
                addr_d  = src_q;
            end
            WR_SRC: begin
                state_d = DONE;
                done_d  = 1'b1;
                cap_d   = dst_piece_q;
                side_d  = ~side_q;
                count_d = count_q + 8'd1;
            end
            DONE, ERR: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    // The next-state values are loaded here, so every output comes straight from a flop.
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: all control and output flops are reset because the outputs must be defined immediately.
        if (RESET) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_piece_q <= '0;
            ready_q     <= 1'b1;
            addr_q      <= '0;
            piece_q     <= '0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cap_q       <= '0;
            side_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments, so all flops update together from pre-edge values.
            state_q     <= state_d;
            src_q       <= src_d;
            dst_piece_q <= dst_piece_d;
            ready_q     <= ready_d;
            addr_q      <= addr_d;
            piece_q     <= piece_d;
            en_q        <= en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            side_q      <= side_d;
            count_q     <= count_d;
        end
    end

    assign move_ready          = ready_q;
    assign board_out_addr      = addr_q;
    assign board_out_piece     = piece_q;
    assign board_change_enable = en_q;
    assign move_done           = done_q;
    assign move_error          = err_q;
    assign captured_piece      = cap_q;
    assign side_to_move        = side_q;
    assign move_count          = count_q;

endmodule
